// File: rtl/menu_key_pkg.sv
// Shared menu key codes, PS/2 set-2 scan-code constants and the scan-to-key lookup.
package menu_key_pkg;

  typedef enum logic [2:0] {
    KEY_NONE     = 3'b000,
    KEY_UP       = 3'b001,
    KEY_DOWN     = 3'b010,
    KEY_LEFT     = 3'b011,
    KEY_RIGHT    = 3'b100,
    KEY_ENTER    = 3'b101,
    KEY_ESCAPE   = 3'b110,
    KEY_RESERVED = 3'b111
  } menu_key_e;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_ESCAPE = 8'h76;

  // Arrow keys exist only in the extended table, enter/escape only in the plain one.
  function automatic menu_key_e decode_key(input logic ext, input logic [7:0] code);
    menu_key_e key;
    key = KEY_NONE;
    if (ext) begin
      case (code)
        SC_UP:    key = KEY_UP;
        SC_DOWN:  key = KEY_DOWN;
        SC_LEFT:  key = KEY_LEFT;
        SC_RIGHT: key = KEY_RIGHT;
        default:  key = KEY_NONE;
      endcase
    end else begin
      case (code)
        SC_ENTER:  key = KEY_ENTER;
        SC_ESCAPE: key = KEY_ESCAPE;
        default:   key = KEY_NONE;
      endcase
    end
    return key;
  endfunction

endpackage

// File: rtl/key_prefix_timer.sv
// Idle-cycle counter that flags an abandoned scan-code prefix.
module key_prefix_timer #(
  parameter int TIMEOUT_CYCLES = 650000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Count idle cycles while a prefix is pending; any byte or leaving the prefix restarts at 0.
  always_comb begin
    count_d = count_q;
    if (!run || clear) count_d = '0;
    else               count_d = count_q + CNT_W'(1);
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  // A byte on the terminal cycle wins, so clear masks the expiry.
  assign expired = run && !clear && (count_q == CNT_LAST);

endmodule

// File: rtl/keyboard_menu_decoder.sv
// PS/2 set-2 scan-code decoder producing held-key code and press strobes for the menu.
//
//   state      | meaning
//   -----------+------------------------------------------
//   ST_IDLE    | no prefix pending, next byte is a make code
//   ST_EXT     | E0 seen, next byte is an extended make (or F0)
//   ST_BRK     | F0 seen, next byte is a plain break
//   ST_EXT_BRK | E0 F0 seen, next byte is an extended break
module keyboard_menu_decoder
  import menu_key_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 650000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ps2_data,
  input  logic       ps2_valid,
  output logic [2:0] keyboard_out,
  output logic       key_pulse,
  output logic       prefix_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } state_e;

  state_e    state_q, state_d;
  menu_key_e held_key_q, held_key_d;
  logic      key_pulse_q, key_pulse_d;
  logic      prefix_timeout_q, prefix_timeout_d;
  logic      timer_run, timer_expired;
  menu_key_e key_plain, key_ext;

  assign timer_run = (state_q != ST_IDLE);
  assign key_plain = decode_key(1'b0, ps2_data);
  assign key_ext   = decode_key(1'b1, ps2_data);

  key_prefix_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (timer_run),
    .clear  (ps2_valid),
    .expired(timer_expired)
  );

  // Next state, held key and strobes; a strobe is suppressed if one fired last cycle.
  always_comb begin
    state_d          = state_q;
    held_key_d       = held_key_q;
    key_pulse_d      = 1'b0;
    prefix_timeout_d = 1'b0;
    if (ps2_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (ps2_data == SC_EXT)      state_d = ST_EXT;
          else if (ps2_data == SC_BRK) state_d = ST_BRK;
          else if (key_plain != KEY_NONE && key_plain != held_key_q) begin
            held_key_d  = key_plain;
            key_pulse_d = !key_pulse_q;
          end
        end
        ST_EXT: begin
          if (ps2_data == SC_BRK) state_d = ST_EXT_BRK;
          else begin
            state_d = ST_IDLE;
            if (key_ext != KEY_NONE && key_ext != held_key_q) begin
              held_key_d  = key_ext;
              key_pulse_d = !key_pulse_q;
            end
          end
        end
        ST_BRK: begin
          state_d = ST_IDLE;
          if (key_plain != KEY_NONE && key_plain == held_key_q) held_key_d = KEY_NONE;
        end
        default: begin
          state_d = ST_IDLE;
          if (key_ext != KEY_NONE && key_ext == held_key_q) held_key_d = KEY_NONE;
        end
      endcase
    end else if (timer_expired) begin
      state_d          = ST_IDLE;
      prefix_timeout_d = !prefix_timeout_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_IDLE;
      held_key_q       <= KEY_NONE;
      key_pulse_q      <= 1'b0;
      prefix_timeout_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      held_key_q       <= held_key_d;
      key_pulse_q      <= key_pulse_d;
      prefix_timeout_q <= prefix_timeout_d;
    end
  end

  assign keyboard_out   = held_key_q;
  assign key_pulse      = key_pulse_q;
  assign prefix_timeout = prefix_timeout_q;

endmodule

// File: tb/tb_keyboard_menu_decoder.sv
// Randomized and directed bench for keyboard_menu_decoder against a sequence-level model.
module tb_keyboard_menu_decoder;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] ps2_data = 8'h00;
  logic       ps2_valid = 1'b0;
  logic [2:0] keyboard_out;
  logic       key_pulse;
  logic       prefix_timeout;

  keyboard_menu_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk           (clk),
    .rst           (rst),
    .ps2_data      (ps2_data),
    .ps2_valid     (ps2_valid),
    .keyboard_out  (keyboard_out),
    .key_pulse     (key_pulse),
    .prefix_timeout(prefix_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: pending prefix bytes kept as a queue, timing by absolute cycle numbers.
  logic [7:0] m_pre[$];
  logic [2:0] m_held = 3'd0;
  bit         m_prev_pulse = 1'b0;
  int         m_cyc = 0;
  int         m_last = 0;
  int         n_pulse = 0;
  int         n_to = 0;

  function automatic logic [2:0] ref_key(input bit ext, input logic [7:0] b);
    if (ext) begin
      if (b == 8'h75) return 3'd1;
      if (b == 8'h72) return 3'd2;
      if (b == 8'h6B) return 3'd3;
      if (b == 8'h74) return 3'd4;
    end else begin
      if (b == 8'h5A) return 3'd5;
      if (b == 8'h76) return 3'd6;
    end
    return 3'd0;
  endfunction

  task automatic step(input bit v, input logic [7:0] d);
    bit         e_pulse, e_to, ext, brk;
    logic [2:0] k;
    e_pulse = 1'b0;
    e_to    = 1'b0;
    ps2_valid = v;
    ps2_data  = v ? d : 8'($urandom);
    m_cyc++;
    if (v) begin
      m_last = m_cyc;
      if ((m_pre.size() == 0 && (d == 8'hE0 || d == 8'hF0)) ||
          (m_pre.size() == 1 && m_pre[0] == 8'hE0 && d == 8'hF0)) begin
        m_pre.push_back(d);
      end else begin
        ext = (m_pre.size() > 0) && (m_pre[0] == 8'hE0);
        brk = (m_pre.size() > 0) && (m_pre[m_pre.size()-1] == 8'hF0);
        k = ref_key(ext, d);
        if (brk) begin
          if (k != 0 && k == m_held) m_held = 3'd0;
        end else if (k != 0 && k != m_held) begin
          m_held  = k;
          e_pulse = !m_prev_pulse;
        end
        m_pre.delete();
      end
    end else if (m_pre.size() > 0 && (m_cyc - m_last) == T) begin
      m_pre.delete();
      e_to = 1'b1;
    end
    m_prev_pulse = e_pulse;
    @(negedge clk);
    ps2_valid = 1'b0;
    check("keyboard_out", 8'(keyboard_out), 8'(m_held));
    check("key_pulse", 8'(key_pulse), 8'(e_pulse));
    check("prefix_timeout", 8'(prefix_timeout), 8'(e_to));
    n_pulse += int'(key_pulse);
    n_to    += int'(prefix_timeout);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b);
    step(1'b0, 8'h00);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    #1;
    check("rst_keyboard_out", 8'(keyboard_out), 8'h00);
    m_pre.delete();
    m_held = 3'd0;
    m_prev_pulse = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("rst_keyboard_out", 8'(keyboard_out), 8'h00);
      check("rst_key_pulse", 8'(key_pulse), 8'h00);
      check("rst_prefix_timeout", 8'(prefix_timeout), 8'h00);
    end
    rst = 1'b1;
  endtask

  logic [7:0] pool[10] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A, 8'h76, 8'h1C, 8'h00};

  initial begin
    @(negedge clk);
    do_reset(3);
    idle(2);

    // V1
    n_pulse = 0;
    send(8'hE0);
    step(1'b1, 8'h75);
    check("v1_key", 8'(keyboard_out), 8'h01);
    check("v1_pulse", 8'(key_pulse), 8'h01);
    idle(1);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("v1_release", 8'(keyboard_out), 8'h00);
    check("v1_pulses", 8'(n_pulse), 8'h01);

    // V2
    n_pulse = 0;
    send(8'h5A); send(8'h5A); send(8'h5A); send(8'h5A);
    check("v2_pulses", 8'(n_pulse), 8'h01);
    check("v2_key", 8'(keyboard_out), 8'h05);

    // V3
    send(8'hF0); send(8'h5A);
    n_pulse = 0;
    send(8'h5A); send(8'hE0); send(8'h72);
    check("v3_pulses", 8'(n_pulse), 8'h02);
    check("v3_key", 8'(keyboard_out), 8'h02);
    send(8'hF0); send(8'h5A);
    check("v3_nonheld_break", 8'(keyboard_out), 8'h02);
    send(8'hF0); send(8'h75);
    check("v3_table_distinct", 8'(keyboard_out), 8'h02);

    // V4
    n_to = 0;
    step(1'b1, 8'hE0);
    idle(T);
    check("v4_timeouts", 8'(n_to), 8'h01);
    send(8'h76);
    check("v4_key", 8'(keyboard_out), 8'h06);

    // V5
    n_to = 0;
    step(1'b1, 8'hE0);
    idle(T - 1);
    step(1'b1, 8'h75);
    idle(T + 2);
    check("v5_timeouts", 8'(n_to), 8'h00);
    check("v5_key", 8'(keyboard_out), 8'h01);

    // V6
    send(8'hE0);
    do_reset(2);
    send(8'h75);
    check("v6_key", 8'(keyboard_out), 8'h00);

    // Random traffic, including back-to-back strobes and long gaps that expire prefixes.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 4) step(1'b1, pool[$urandom_range(0, 9)]);
      else if (r < 5) step(1'b1, 8'($urandom));
      else if (r < 6) idle(int'($urandom_range(T - 2, T + 2)));
      else step(1'b0, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keyboard_menu_decoder.md
KEYBOARD_MENU_DECODER -- requirements
Module: keyboard_menu_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 650000, is the prefix-abandon timeout in clk cycles (10 ms at 65 MHz).
REQ-002 clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 ps2_data  input  8  PS/2 set-2 scan-code byte, valid only when ps2_valid=1.
REQ-005 ps2_valid  input  1  one-cycle strobe marking a new ps2_data byte.
REQ-006 keyboard_out  output  3  code of the currently held menu key, feeding the menu keyboard_in bus.
REQ-007 key_pulse  output  1  one-cycle strobe on each new key press.
REQ-008 prefix_timeout  output  1  one-cycle strobe when a pending prefix is abandoned.

Function
REQ-009 Key codes SHALL be: 000 none, 001 up, 010 down, 011 left, 100 right, 101 enter, 110 escape, 111 reserved (never driven).
REQ-010 Scan-code mapping SHALL be:
- E0 75 = up
- E0 72 = down
- E0 6B = left
- E0 74 = right
- 5A = enter
- 76 = escape
- every other code SHALL be ignored without changing outputs.
REQ-011 The FSM SHALL have the states IDLE, EXT (after E0), BRK (after F0) and EXT_BRK (after E0 F0).
REQ-012 Transitions:
- IDLE: E0 goes to EXT; F0 goes to BRK; any other byte is a make code and the FSM stays in IDLE.
- EXT: F0 goes to EXT_BRK; any other byte is an extended make code, then IDLE.
- BRK: any byte is a non-extended break, then IDLE.
- EXT_BRK: any byte is an extended break, then IDLE.
REQ-013 Prefix bytes received in an unexpected state (for example E0 while in EXT) SHALL be treated as ordinary data bytes of that state.
REQ-014 A mapped make code SHALL set keyboard_out to its code and assert key_pulse, one cycle after the ps2_valid carrying the final byte.
REQ-015 A typematic repeat (a make code equal to the currently held key) SHALL leave keyboard_out unchanged and SHALL NOT assert key_pulse.
REQ-016 A make code for a different mapped key while a key is held SHALL replace the held key (last-pressed wins) and assert key_pulse.
REQ-017 A break code of the held key SHALL drive keyboard_out to 000 one cycle after its final byte.
REQ-018 A break code of a non-held key SHALL be ignored.
REQ-019 The extended and non-extended tables SHALL be distinct: a break code must match the held key in both code and extension.
- Example: F0 75 does not release up.
REQ-020 In EXT, BRK or EXT_BRK, the timeout counter SHALL increment every cycle without ps2_valid and SHALL reset to 0 on each ps2_valid.
REQ-021 When the counter reaches TIMEOUT_CYCLES-1, the FSM SHALL return to IDLE and prefix_timeout SHALL pulse for one cycle.
- keyboard_out SHALL be unchanged.
REQ-022 The counter SHALL hold at 0 in IDLE.
REQ-023 The counter width SHALL be ceil(log2(TIMEOUT_CYCLES)).
REQ-024 If ps2_valid coincides with the timeout cycle, the byte SHALL take priority: it is processed normally and no timeout occurs.
REQ-025 key_pulse and prefix_timeout SHALL never be high for two consecutive cycles.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 While rst=0, the FSM SHALL be in IDLE, and keyboard_out=000, key_pulse=0, prefix_timeout=0, the held-key register=000 and the timeout counter=0.
REQ-028 A reset asserted mid-sequence (for example after E0) SHALL discard the partial sequence.
- After release, the next byte SHALL be decoded from IDLE.
REQ-029 On the first cycle after rst rises, outputs SHALL remain at their reset values until a byte is decoded.

Structure
REQ-030 Key codes (REQ-009) and scan-code constants (E0, F0, 75, 72, 6B, 74, 5A, 76) SHALL live in the shared package menu_key_pkg, which the menu FSM also uses.
REQ-031 The FSM state encoding SHALL be local to keyboard_menu_decoder.
REQ-032 The timeout counter SHALL be the single sub-module key_prefix_timer, with ports clk, rst, run, clear and expired.

Verification
REQ-033 The bench SHALL cover these directed scenarios (TIMEOUT_CYCLES=16 in simulation):
- V1: E0, 75 -> keyboard_out=001 and key_pulse=1 one cycle after the 75 strobe; then E0 F0 75 -> keyboard_out=000 with no pulse.
- V2: 5A, then 5A repeated 3 times -> exactly one key_pulse; keyboard_out stays 101.
- V3: 5A, then E0 72 -> two pulses and keyboard_out=010; then F0 5A -> keyboard_out stays 010.
- V4: E0, then 16 idle cycles -> prefix_timeout pulses once and the FSM is in IDLE; a following 76 -> keyboard_out=110.
- V5: E0, with a strobe of 75 on exactly cycle 15 -> no prefix_timeout; keyboard_out=001.
- V6: E0 then rst=0 for 2 cycles then rst=1, then 75 -> treated as non-extended and unmapped; keyboard_out stays 000.
